// File: rtl/button_event.sv
// Press-event decoder: turns a debounced button level into one-cycle pulses for
// press start, short press, long press and auto-repeat while held.
module button_event #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_start,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             held_q, held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  // One counter serves both the long-press threshold and the repeat period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_level) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_d = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Release is tested first so it wins over the long-press threshold.
  always_comb begin
    press_d = (state_q == IDLE) && btn_level;
    short_d = (state_q == PRESSED) && !btn_level;
    long_d  = (state_q == PRESSED) && btn_level && (cnt_q == LONG_LAST);
    rep_d   = (state_q == REPEAT) && btn_level && (cnt_q == REPEAT_LAST);
    held_d  = (state_d == PRESSED) || (state_d == REPEAT);
  end

  assign press_start = press_q;
  assign short_press = short_q;
  assign long_press  = long_q;
  assign repeat_tick = rep_q;
  assign held        = held_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus random presses,
// compared against a press-duration reference model.
module tb_button_event;

  localparam int LONG_CNT   = 8;
  localparam int REPEAT_CNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic press_start, short_press, long_press, repeat_tick, held;

  int checks = 0;
  int errors = 0;

  // Reference model: whether a press is in progress and edges elapsed since E0.
  bit mPressed = 1'b0;
  int mAge = 0;
  logic ePress, eShort, eLong, eRep, eHeld;

  button_event #(
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_level  (btn_level),
    .press_start(press_start),
    .short_press(short_press),
    .long_press (long_press),
    .repeat_tick(repeat_tick),
    .held       (held)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    int n;
    checkOutput("press_start", press_start, ePress);
    checkOutput("short_press", short_press, eShort);
    checkOutput("long_press", long_press, eLong);
    checkOutput("repeat_tick", repeat_tick, eRep);
    checkOutput("held", held, eHeld);
    n = int'(press_start) + int'(short_press) + int'(long_press) + int'(repeat_tick);
    checkOutput("one_pulse_max", n <= 1, 1'b1);
  endtask

  // Model update for one sampled edge, derived from press duration only.
  task automatic modelEdge(input logic b);
    ePress = 1'b0; eShort = 1'b0; eLong = 1'b0; eRep = 1'b0;
    if (!mPressed) begin
      if (b) begin
        mPressed = 1'b1;
        mAge = 0;
        ePress = 1'b1;
      end
    end else begin
      mAge++;
      if (!b) begin
        mPressed = 1'b0;
        eShort = (mAge <= LONG_CNT);
      end else begin
        eLong = (mAge == LONG_CNT);
        eRep = (mAge > LONG_CNT) && ((mAge - LONG_CNT) % REPEAT_CNT == 0);
      end
    end
    eHeld = mPressed;
  endtask

  task automatic applyStimulus(input logic b);
    btn_level = b;
    @(posedge clk);
    modelEdge(b);
    #1;
    checkAll();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    mPressed = 1'b0;
    mAge = 0;
    ePress = 1'b0; eShort = 1'b0; eLong = 1'b0; eRep = 1'b0; eHeld = 1'b0;
    checkAll();
    repeat (2) begin
      @(posedge clk);
      #1;
      checkAll();
    end
  endtask

  task automatic releaseReset(input logic b);
    @(negedge clk);
    btn_level = b;
    rst = 1'b0;
  endtask

  initial begin
    ePress = 1'b0; eShort = 1'b0; eLong = 1'b0; eRep = 1'b0; eHeld = 1'b0;
    #2;
    applyReset();
    releaseReset(1'b0);

    $display("[TB] idle after reset");
    repeat (20) applyStimulus(1'b0);

    $display("[TB] short press of 3 cycles");
    repeat (3) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);

    $display("[TB] 30-cycle hold with repeat");
    repeat (30) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);

    $display("[TB] boundary: 8 and 9 high samples");
    repeat (8) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);
    repeat (9) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);

    $display("[TB] reset during REPEAT");
    repeat (LONG_CNT + 3) applyStimulus(1'b1);
    applyReset();
    releaseReset(1'b1);
    repeat (12) applyStimulus(1'b1);
    repeat (2) applyStimulus(1'b0);

    $display("[TB] two 1-cycle presses");
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    $display("[TB] random presses");
    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 22);
      lo = $urandom_range(1, 4);
      repeat (hi) applyStimulus(1'b1);
      repeat (lo) applyStimulus(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Press-event decoder for the clock's setting buttons. It takes the debounced, active-high button level and turns each press into one-cycle event pulses: press start, short press (released before the long-press threshold), long press, and periodic auto-repeat while the button stays held. Each front-panel button has one instance, placed directly after that button's debouncer. The time-set logic uses the pulses to step hours and minutes, with fast stepping while a button is held.

## Interface
- LONG_CNT, 50_000_000 — hold time in clk cycles before long_press (1 s at 50 MHz); must be ≥ 2
- REPEAT_CNT, 10_000_000 — clk cycles between repeat_tick pulses after long_press (200 ms); must be ≥ 2
- CNT_W, 26 — counter width; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT) − 1
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- btn_level  input  1  debounced button level, 1 = pressed; synchronous to clk
- press_start  output  1  one-cycle pulse when a press is recognised
- short_press  output  1  one-cycle pulse on release of a press shorter than the long-press threshold
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CNT
- repeat_tick  output  1  one-cycle pulse every REPEAT_CNT cycles after long_press while held
- held  output  1  level, high while the FSM is in PRESSED or REPEAT

## Operation
- FSM states: IDLE, PRESSED, REPEAT. One counter (CNT_W bits) is shared by PRESSED and REPEAT.
- IDLE: if btn_level = 1 at an edge → PRESSED, counter ← 0, press_start ← 1.
- PRESSED, at each edge:
  - If btn_level = 0 → IDLE, short_press ← 1.
  - Otherwise, if counter = LONG_CNT−1 → REPEAT, counter ← 0, long_press ← 1.
  - Otherwise, counter ← counter+1.
- REPEAT, at each edge:
  - If btn_level = 0 → IDLE. No pulse is generated on release after a long press.
  - Otherwise, if counter = REPEAT_CNT−1 → repeat_tick ← 1, counter ← 0.
  - Otherwise, counter ← counter+1.
- All pulse outputs are registered, default 0, and last exactly one cycle. At most one pulse output is high in any cycle.
- held is registered and equals 1 whenever the state is PRESSED or REPEAT.
- Release takes priority over threshold: if btn_level = 0 at the edge where counter = LONG_CNT−1, the result is short_press, not long_press.
- Counter compares use equality only. The counter never wraps, because it is cleared at each threshold.
- A press in progress when reset is released is not suppressed. If btn_level = 1 at the first edge after reset, that edge is treated as a new press.

## Timing
- Reset (async assert, applies immediately): state = IDLE, counter = 0, and press_start, short_press, long_press, repeat_tick and held are all 0.
- Let E0 be the edge at which btn_level is first sampled high in IDLE.
  - press_start and held are high in the cycle after E0.
  - long_press is high in the cycle after edge E0+LONG_CNT, provided btn_level was sampled high at every edge from E0 through E0+LONG_CNT.
  - repeat_tick is high in the cycle after each edge E0+LONG_CNT+k·REPEAT_CNT, for k ≥ 1, while still held.
- Release sampled low at edge Er:
  - If E0 < Er ≤ E0+LONG_CNT → short_press in the cycle after Er.
  - held falls in the cycle after Er in both the short and the long case.
- Minimum press: high at E0 and low at E0+1 gives press_start after E0 and short_press after E0+1, in back-to-back cycles.
- A new press can be recognised at the edge immediately after returning to IDLE.
- Asserting reset mid-press aborts the press with no pulse. All outputs are 0 while rst = 1.

## Test plan
Bench parameters: LONG_CNT = 8, REPEAT_CNT = 4.
- Reset with btn_level = 0, then idle 20 cycles → all outputs 0, no pulses.
- Hold btn_level high for 3 cycles, then low → press_start once; held for 3 cycles; short_press once in the cycle held falls; no long_press.
- Hold btn_level high for 30 cycles from E0 → press_start after E0; long_press after E0+8; repeat_tick after E0+12, E0+16, E0+20, E0+24 and E0+28; release produces no short_press.
- Boundary: btn_level high for exactly 8 samples (E0..E0+7), low at E0+8 → short_press after E0+8; long_press never asserted. The same press with 9 high samples → long_press after E0+8; no short_press.
- Assert rst in REPEAT mid-count, then deassert with btn_level high → outputs go to 0 immediately; press_start follows the first post-reset edge; long_press follows 8 edges after that.
- Two 1-cycle presses separated by one low cycle → two press_start pulses and two short_press pulses; no pulse ever overlaps another.
